// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key code valid/ready hand-off between scanner and input decoder
interface keypad_scanner_if #(
    parameter int CODE_W = 4
) ();
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad row scan, debounce and key-code hand-off (optional KEYPAD_AUTOREPEAT_EN)
module keypad_scanner #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SCAN_DIV      = 16,
    parameter int DEBOUNCE_CNT  = 1000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row_drive,
    input  logic [COLS-1:0]   col_in,
    keypad_scanner_if.master  key_if,
    output logic              key_held,
    output logic              overrun
);
    localparam int CODE_W  = (ROWS * COLS > 2) ? $clog2(ROWS * COLS) : 1;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_CNT);

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CNT - 1);

    // Reject parameter sets the counters and index widths are not sized for.
    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 ||
        DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d, row_next;
    logic [COL_W-1:0]   col_q, col_d, press_col;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COLS-1:0]    col_m, col_s;
    logic               press_any;
    logic               emit;
    logic [CODE_W-1:0]  code_q, new_code;
    logic               valid_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_phase_q, rep_phase_d;
`endif

    // Two-flop synchroniser for the asynchronous column pins; idle is all-released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_m <= '1;
            col_s <= '1;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    // Lowest pressed column wins when several are low together.
    always_comb begin
        press_any = 1'b0;
        press_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_s[c]) begin
                press_any = 1'b1;
                press_col = COL_W'(c);
            end
        end
    end

    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    assign new_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);

    // Active-low row enable: only the current row is pulled low outside reset.
    always_comb begin
        row_drive = '1;
        if (!rst) begin
            row_drive[row_q] = 1'b0;
        end
    end

    // FSM state and scan/debounce counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            row_q       <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    // Next-state logic: scan rows, debounce the latched column, wait for a clean release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_phase_d = rep_phase_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (press_any) begin
                        col_d   = press_col;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s[col_q]) begin
                    // Bounced open before it settled: abandon silently.
                    state_d = SCAN;
                    row_d   = row_next;
                    dwell_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_phase_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (col_s[col_q]) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
                    rep_phase_d = 1'b0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d = SCAN;
                        row_d   = row_next;
                        dwell_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    // First repeat after the long delay, then at the shorter period.
                    if ((!rep_phase_q && rep_q == REP_DELAY_LAST) ||
                        (rep_phase_q && rep_q == REP_PERIOD_LAST)) begin
                        emit        = 1'b1;
                        rep_d       = '0;
                        rep_phase_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Output holding register: load on emit when free (or freed this cycle), else flag an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!valid_q || key_if.key_ready) begin
                    code_q  <= new_code;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && key_if.key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_held         = (state_q == HELD);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_drive;
    logic [3:0]  col_in;
    logic        key_held;
    logic        overrun;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;

    keypad_scanner_if #(.CODE_W(4)) kif ();

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(8),
        .REPEAT_DELAY(40), .REPEAT_PERIOD(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_drive (row_drive),
        .col_in    (col_in),
        .key_if    (kif),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed switch pulls its column low while its row is driven.
    always_comb begin
        col_in = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_drive[r]) col_in[c] = 1'b0;
            end
        end
    end

    // Event recorder: cycle stamps of key_valid rising edges and overrun pulse count.
    int   cyc = 0;
    int   rise_n = 0;
    int   rise_t [64];
    int   ov_n = 0;
    logic v_prev = 1'b0;
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        v_prev <= kif.key_valid;
        if (kif.key_valid && !v_prev) begin
            if (rise_n < 64) rise_t[rise_n] <= cyc;
            rise_n <= rise_n + 1;
        end
        if (overrun) ov_n <= ov_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (kif.key_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_held(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (key_held === v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int n0, n1, o0;
        bit saw_row1;

        vecs[0] = '{keys: 16'h0040, code: 4'd6};
        vecs[1] = '{keys: 16'h0A00, code: 4'd9};
        vecs[2] = '{keys: 16'h8000, code: 4'd15};
        vecs[3] = '{keys: 16'h1000, code: 4'd12};
        vecs[4] = '{keys: 16'h0008, code: 4'd3};
        vecs[5] = '{keys: 16'h0001, code: 4'd0};

        kif.key_ready = 1'b0;

        // Reset values and scan order
        repeat (3) tick();
        check("rst_row_drive", row_drive, 4'b1111);
        check("rst_key_code", kif.key_code, 0);
        check("rst_key_valid", kif.key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] exp_rd;
            exp_rd = ~(4'b0001 << ((i / 4) % 4));
            check("scan_row_drive", row_drive, exp_rd);
            tick();
        end

        // Single presses from the vector table, consumer initially stalled
        for (int i = 0; i < 6; i++) begin
            keys = vecs[i].keys;
            wait_valid(ok);
            check("press_seen", ok, 1);
            check("key_code", kif.key_code, vecs[i].code);
            check("key_held_on", key_held, 1);
            n0 = rise_n;
            repeat (10) tick();
            check("valid_stays", kif.key_valid, 1);
            check("code_stable", kif.key_code, vecs[i].code);
            kif.key_ready = 1'b1;
            tick();
            kif.key_ready = 1'b0;
            check("valid_drop", kif.key_valid, 0);
            keys = '0;
            wait_held(1'b0, ok);
            check("release_seen", ok, 1);
            check("single_transfer", rise_n - n0, 0);
            check("valid_after_release", kif.key_valid, 0);
        end

        // Bouncing contact on key 0 never settles
        n0 = rise_n;
        saw_row1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) keys[0] = ~keys[0];
            tick();
            if (row_drive == 4'b1101) saw_row1 = 1'b1;
        end
        keys = '0;
        repeat (10) tick();
        check("bounce_no_valid", rise_n - n0, 0);
        check("bounce_scan_moves", saw_row1, 1);
        check("bounce_not_held", key_held, 0);

        // Overrun: key 0 left untransferred, then key 15 accepted
        keys = 16'h0001;
        wait_valid(ok);
        check("ovr_first_seen", ok, 1);
        check("ovr_first_code", kif.key_code, 0);
        keys = '0;
        wait_held(1'b0, ok);
        check("ovr_first_release", ok, 1);
        o0 = ov_n;
        keys = 16'h8000;
        wait_held(1'b1, ok);
        check("ovr_second_held", ok, 1);
        repeat (5) tick();
        check("ovr_pulse_count", ov_n - o0, 1);
        check("ovr_code_kept", kif.key_code, 0);
        check("ovr_valid_kept", kif.key_valid, 1);
        kif.key_ready = 1'b1;
        tick();
        kif.key_ready = 1'b0;
        check("ovr_valid_drop", kif.key_valid, 0);
        keys = '0;
        wait_held(1'b0, ok);
        check("ovr_second_release", ok, 1);

        // Long hold of key 5 with the consumer always ready
        kif.key_ready = 1'b1;
        keys = 16'h0020;
        wait_valid(ok);
        check("hold_seen", ok, 1);
        check("hold_code", kif.key_code, 5);
        n0 = rise_n;
        repeat (70) tick();
`ifdef KEYPAD_AUTOREPEAT_EN
        check("repeat_emits", rise_n - n0 + 1, 3);
        if (rise_n >= n0 + 2) begin
            check("repeat_delay", rise_t[n0] - rise_t[n0-1], 40);
            check("repeat_period", rise_t[n0+1] - rise_t[n0], 20);
        end
`else
        check("single_emit_hold", rise_n - n0 + 1, 1);
`endif
        check("hold_still_held", key_held, 1);

        // Asynchronous reset in the middle of the hold
        #2;
        rst = 1'b1;
        #1;
        check("midrst_row_drive", row_drive, 4'b1111);
        check("midrst_key_code", kif.key_code, 0);
        check("midrst_key_valid", kif.key_valid, 0);
        check("midrst_key_held", key_held, 0);
        check("midrst_overrun", overrun, 0);
        keys = '0;
        repeat (3) tick();
        rst = 1'b0;
        n1 = rise_n;
        repeat (100) tick();
        check("no_emit_after_reset", rise_n - n1, 0);
        check("not_held_after_reset", key_held, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
